sipo_rx: RTL and testbench
==========================

# sipo_rx

Serial-in/parallel-out receiver. Collects framed serial bits into a WIDTH-bit word and presents it on a parallel output with a valid/ready handshake. It is the receive end of the serial link whose transmit end is the parallel-load shifter. It sits between the serial pins and the parallel register bank, with a single-entry output buffer so that reception continues while a word waits to be taken.

## Interface
- WIDTH, 4, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in out_data[WIDTH-1]; 0 = first bit lands in out_data[0].

- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately while low.
- s_valid  in  1  a serial bit is present on s_data this cycle.
- s_data  in  1  serial data bit.
- s_frame  in  1  marks the first bit of a word; only meaningful when s_valid=1.
- out_data  out  WIDTH  received word, held stable while out_valid=1.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.
- busy  out  1  a word is partially received (FSM in SHIFT).
- overrun  out  1  one-cycle pulse: a completed word was dropped.
- frame_err  out  1  one-cycle pulse: s_frame arrived mid-word.

## Operation
- Reset values: out_data=0, out_valid=0, busy=0, overrun=0, frame_err=0, shift register=0, bit count=0, FSM=IDLE.
- FSM states:
  - IDLE: the block waits for a frame.
    - s_valid && s_frame: capture the bit, set count=1, go to SHIFT.
    - s_valid && !s_frame: bit ignored.
  - SHIFT: a word is being received.
    - s_valid && !s_frame: capture the bit and increment count.
    - s_valid with count==WIDTH-1: the word is complete. Go to IDLE with count=0.
    - s_valid && s_frame: discard the partial word, pulse frame_err, capture this bit as the new first bit, set count=1, stay in SHIFT.
    - !s_valid: hold state and count; gaps of any length are allowed.
- Capture order:
  - MSB_FIRST=1: shift={shift[WIDTH-2:0], s_data}.
  - MSB_FIRST=0: shift={s_data, shift[WIDTH-1:1]}.
- On word completion, the completed word includes the bit captured in that same cycle. What happens to it depends on the output buffer:
  - out_valid=0: load out_data, set out_valid=1.
  - out_valid=1 && out_ready=1: the old word is consumed, the new word is loaded, and out_valid stays 1.
  - out_valid=1 && out_ready=0: the new word is dropped, overrun pulses, and out_data and out_valid are unchanged.
- Handshake without completion: out_valid && out_ready clears out_valid. out_data keeps its last value.
- busy=1 exactly when the FSM is in SHIFT.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Latency: last bit sampled at edge k, so out_valid=1 and out_data are valid from edge k onward, i.e. visible in cycle k+1.
- Minimum word time is WIDTH cycles. Back-to-back words with out_ready held at 1 sustain one word per WIDTH cycles with no bubble.
- overrun and frame_err are high for exactly one cycle, after the edge that detected the event.
- Reset mid-word or with out_valid=1 drops everything. The first s_valid&&s_frame after reset release starts a clean word.

## Structure
- Package sipo_pkg holds the FSM state typedef (IDLE, SHIFT) and the count-width constant $clog2(WIDTH).
- Sub-module sipo_rx_shift: shift register plus bit counter, parameterised by WIDTH and MSB_FIRST. It takes capture/restart controls from the FSM and returns the word and a last-bit flag.
- Top level contains the FSM, the output buffer and handshake, and the pulse flags.

## Test plan
All scenarios use WIDTH=4, MSB_FIRST=1 unless stated.

- Bits 1,0,1,1 (frame on first), consecutive cycles, out_ready=1 -> out_data=4'b1011, out_valid high for one cycle after the 4th bit; busy high for 3 cycles.
- Same bits with 2 idle cycles between each bit -> out_data=4'b1011, busy held through the gaps, no flags.
- Word 4'hA received, out_ready=0, then word 4'h5 completes -> overrun pulses once, out_data stays 4'hA. Then out_ready=1 -> 4'hA consumed, out_valid drops.
- Word 4'hA pending, out_ready=1 in the cycle 4'h5 completes -> out_data=4'h5, out_valid stays 1, no overrun.
- Bits 1,1 then frame with bits 1,0,0,1 -> frame_err one pulse, out_data=4'b1001.
- reset low after 2 bits -> all outputs 0 immediately. After release, with MSB_FIRST=0, bits 1,0,0,0 -> out_data=4'b0001.

Source files
------------

// File: rtl/sipo_rx_pkg.sv
// Shared types and helpers for the serial-in/parallel-out receiver.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 4;

    // Bit-counter width: holds 0..WIDTH-1.
    function automatic int count_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_rx_shift.sv
// Shift register and bit counter for sipo_rx; the FSM supplies capture/restart controls.
module sipo_rx_shift
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture,
    input  logic             restart,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word_next,
    output logic             last
);

    localparam int CW = count_width(WIDTH);

    logic [WIDTH-1:0] shift_q, shift_d, shift_next;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        shift_next = shift_q;
        if (MSB_FIRST) begin
            shift_next = {shift_q[WIDTH-2:0], bit_in};
        end else begin
            shift_next = {bit_in, shift_q[WIDTH-1:1]};
        end

        last      = (count_q == CW'(WIDTH - 1));
        word_next = shift_next;
        shift_d   = capture ? shift_next : shift_q;

        // A restart bit is the first bit of a fresh word, so it outranks completion.
        count_d = count_q;
        if (restart) begin
            count_d = CW'(1);
        end else if (capture) begin
            count_d = last ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: framing FSM, single-entry output buffer and event pulses.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    input  logic             s_data,
    input  logic             s_frame,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic             capture, restart, last, complete;
    logic [WIDTH-1:0] word_next;

    sipo_rx_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .capture   (capture),
        .restart   (restart),
        .bit_in    (s_data),
        .word_next (word_next),
        .last      (last)
    );

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;

        restart  = s_valid && s_frame;
        capture  = s_valid && (s_frame || (state_q == SHIFT));
        complete = (state_q == SHIFT) && s_valid && !s_frame && last;

        case (state_q)
            IDLE: begin
                if (restart) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (restart) begin
                    frame_err_d = 1'b1;
                end else if (complete) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A word being consumed this cycle frees the buffer for the new one.
        if (complete) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = word_next;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == SHIFT);
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: one MSB-first and one LSB-first instance share the same serial stream.
module tb_sipo_rx;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic s_valid = 1'b0, s_data = 1'b0, s_frame = 1'b0, out_ready = 1'b0;

    logic [W-1:0] od_m, od_l;
    logic ov_m, ov_l, busy_m, busy_l, or_m, or_l, fe_m, fe_l;

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset_n), .s_valid(s_valid), .s_data(s_data), .s_frame(s_frame),
        .out_data(od_m), .out_valid(ov_m), .out_ready(out_ready),
        .busy(busy_m), .overrun(or_m), .frame_err(fe_m)
    );

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset_n), .s_valid(s_valid), .s_data(s_data), .s_frame(s_frame),
        .out_data(od_l), .out_valid(ov_l), .out_ready(out_ready),
        .busy(busy_l), .overrun(or_l), .frame_err(fe_l)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic busy;
        logic valid;
        logic ovr;
        logic ferr;
    } status_t;

    status_t      st_q[$];
    logic [W-1:0] wq_m[$];
    logic [W-1:0] wq_l[$];

    // Reference model: the bits of the word in progress, in arrival order.
    int           m_len = 0;
    logic [31:0]  m_bits = '0;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_buf_m = '0, m_buf_l = '0;
    logic         m_ovr = 1'b0, m_ferr = 1'b0;

    function automatic logic [W-1:0] assemble(input logic [31:0] b, input bit msb);
        int w;
        w = 0;
        for (int i = 0; i < W; i++) begin
            if (msb) w = w * 2 + int'(b[i]);
            else     w = w + (int'(b[i]) << i);
        end
        return W'(w);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic modelReset();
        m_len = 0; m_bits = '0; m_valid = 1'b0;
        m_buf_m = '0; m_buf_l = '0; m_ovr = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic modelStep(input logic v, input logic d, input logic f, input logic r);
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        if (m_valid && r) begin
            wq_m.push_back(m_buf_m);
            wq_l.push_back(m_buf_l);
            m_valid = 1'b0;
        end
        if (v) begin
            if (f) begin
                if (m_len > 0) m_ferr = 1'b1;
                m_bits = '0;
                m_bits[0] = d;
                m_len = 1;
            end else if (m_len > 0) begin
                m_bits[m_len] = d;
                m_len++;
                if (m_len == W) begin
                    m_len = 0;
                    if (!m_valid) begin
                        m_buf_m = assemble(m_bits, 1'b1);
                        m_buf_l = assemble(m_bits, 1'b0);
                        m_valid = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic pushStatus();
        status_t s;
        s.busy = (m_len > 0);
        s.valid = m_valid;
        s.ovr = m_ovr;
        s.ferr = m_ferr;
        st_q.push_back(s);
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic d, input logic f, input logic r);
        @(negedge clk);
        reset_n = rst; s_valid = v; s_data = d; s_frame = f; out_ready = r;
        if (!rst) modelReset();
        else modelStep(v, d, f, r);
        pushStatus();
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0; s_valid = 1'b0; s_data = 1'b0; s_frame = 1'b0; out_ready = 1'b0;
        modelReset();
        pushStatus();
        #1;
        checkOutput("reset_immediate",
                    {od_m, od_l, ov_m, ov_l, busy_m, busy_l, or_m, or_l, fe_m, fe_l}, '0);
    endtask

    task automatic sendWord(input logic [W-1:0] w, input int gap, input logic r);
        for (int i = W - 1; i >= 0; i--) begin
            applyStimulus(1'b1, 1'b1, w[i], (i == W - 1), r);
            if (i > 0) repeat (gap) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, r);
        end
    endtask

    // Per-cycle flag/status monitor.
    always begin
        status_t e;
        @(posedge clk);
        #1;
        if (st_q.size() > 0) begin
            e = st_q.pop_front();
            checkOutput("status_msb", {busy_m, ov_m, or_m, fe_m}, e);
            checkOutput("status_lsb", {busy_l, ov_l, or_l, fe_l}, e);
        end
    end

    // Handshake monitor: a word is taken whenever valid and ready meet.
    always begin
        @(negedge clk);
        #1;
        if (reset_n && out_ready) begin
            if (ov_m) begin
                if (wq_m.size() == 0) checkOutput("word_msb_unexpected", {31'd0, ov_m}, 32'd0);
                else checkOutput("word_msb", od_m, wq_m.pop_front());
            end
            if (ov_l) begin
                if (wq_l.size() == 0) checkOutput("word_lsb_unexpected", {31'd0, ov_l}, 32'd0);
                else checkOutput("word_lsb", od_l, wq_l.pop_front());
            end
        end
    end

    initial begin
        logic f, r;
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("reset_state",
                    {od_m, od_l, ov_m, ov_l, busy_m, busy_l, or_m, or_l, fe_m, fe_l}, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        sendWord(4'b1011, 0, 1'b1);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        sendWord(4'b1011, 2, 1'b1);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        sendWord(4'hA, 0, 1'b0);
        sendWord(4'h5, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        sendWord(4'hA, 0, 1'b0);
        for (int i = W - 1; i >= 0; i--) begin
            logic [W-1:0] w5;
            w5 = 4'h5;
            applyStimulus(1'b1, 1'b1, w5[i], (i == W - 1), (i == 0));
        end
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        sendWord(4'b1001, 0, 1'b1);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        sendWord(4'b1000, 0, 1'b1);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                doReset();
                applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                if (m_len == 0)          f = ($urandom_range(0, 9) < 8);
                else if (m_len == W - 1) f = 1'b0;
                else                     f = ($urandom_range(0, 19) == 0);
                r = ($urandom_range(0, 9) < 6);
                applyStimulus(1'b1, ($urandom_range(0, 9) < 7), 1'($urandom), f, r);
            end
        end

        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        checkOutput("words_left_msb", wq_m.size(), 0);
        checkOutput("words_left_lsb", wq_l.size(), 0);
        checkOutput("status_left", st_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
